// File: rtl/core_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core_memory_arbiter
//  Purpose  : Shares one core memory port between NUM_PORTS masters.
//             Round-robin grant, one outstanding transaction at a time,
//             per-port response routing and a watchdog that aborts a WAIT
//             with a one-cycle bus-error pulse if memory never answers.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset                   clock, asynchronous active-high reset
//    port_memory_enable/command   per-port request and command (1 = write)
//    port_read/write_memory_*     packed per-port address / data / mask,
//                                 port i at [i*W +: W]
//    port_memory_ready            per-port accept (owner only, in ISSUE)
//    port_memory_valid            per-port one-cycle completion pulse
//    port_read_memory_data        read data, qualified by port_memory_valid
//    port_bus_error               per-port one-cycle timeout pulse
//    memory_ready/valid           downstream accept / completion
//    read_memory_data             downstream read data
//    read/write_memory_*,
//    memory_command/enable        downstream request
//    busy                         arbiter not idle
//    debug_owner                  current or most recent owner
// ============================================================================
module core_memory_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_memory_enable,
   input  logic [NUM_PORTS-1:0]             port_memory_command,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_read_memory_address,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_write_memory_address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_memory_data,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_write_memory_mask,
   output logic [NUM_PORTS-1:0]             port_memory_ready,
   output logic [NUM_PORTS-1:0]             port_memory_valid,
   output logic [DATA_WIDTH-1:0]            port_read_memory_data,
   output logic [NUM_PORTS-1:0]             port_bus_error,
   input  logic                             memory_ready,
   input  logic                             memory_valid,
   input  logic [DATA_WIDTH-1:0]            read_memory_data,
   output logic [ADDR_WIDTH-1:0]            read_memory_address,
   output logic [ADDR_WIDTH-1:0]            write_memory_address,
   output logic [DATA_WIDTH-1:0]            write_memory_data,
   output logic [DATA_WIDTH-1:0]            write_memory_mask,
   output logic                             memory_command,
   output logic                             memory_enable,
   output logic                             busy,
   output logic [$clog2(NUM_PORTS)-1:0]     debug_owner
);

   localparam int c_owner_w = $clog2(NUM_PORTS);
   // TIMEOUT = 0 disables the watchdog; keep at least one bit so the
   // counter stays a legal vector.
   localparam int c_wd_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit c_wd_en = (TIMEOUT > 0);
   localparam logic [c_wd_w-1:0] c_wd_limit =
      (TIMEOUT > 0) ? c_wd_w'(TIMEOUT - 1) : '0;
   localparam logic [c_wd_w-1:0]    c_wd_max    = '1;
   localparam logic [c_owner_w-1:0] c_last_rst  = c_owner_w'(NUM_PORTS - 1);
   localparam logic [NUM_PORTS-1:0] c_one       = NUM_PORTS'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_owner_w-1:0]  r_owner;
   logic [c_owner_w-1:0]  w_owner_nxt;
   logic [c_owner_w-1:0]  r_last_grant;
   logic [c_owner_w-1:0]  w_last_nxt;
   logic [c_wd_w-1:0]     r_watchdog;
   logic [c_wd_w-1:0]     w_wd_nxt;

   logic [NUM_PORTS-1:0]  w_owner_oh;
   logic                  w_expired;
   logic                  w_hi_found;
   logic                  w_lo_found;
   logic [c_owner_w-1:0]  w_hi_pick;
   logic [c_owner_w-1:0]  w_lo_pick;
   logic [c_owner_w-1:0]  w_grant;
   logic                  w_any_req;

   logic [ADDR_WIDTH-1:0] w_raddr [NUM_PORTS];
   logic [ADDR_WIDTH-1:0] w_waddr [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wmask [NUM_PORTS];

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign w_raddr[gi] = port_read_memory_address [gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_waddr[gi] = port_write_memory_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata[gi] = port_write_memory_data   [gi*DATA_WIDTH +: DATA_WIDTH];
         assign w_wmask[gi] = port_write_memory_mask   [gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   assign w_owner_oh  = c_one << r_owner;
   assign w_expired   = c_wd_en && (r_watchdog == c_wd_limit);
   assign busy        = (r_state != S_IDLE);
   assign debug_owner = r_owner;

   // Round-robin pick: the lowest requester above last_grant wins; if there
   // is none, wrap and take the lowest requester at or below last_grant.
   // Scanning downward leaves the lowest index in each group.
   always_comb begin
      w_hi_found = 1'b0;
      w_lo_found = 1'b0;
      w_hi_pick  = '0;
      w_lo_pick  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_memory_enable[i]) begin
            if (i > int'(r_last_grant)) begin
               w_hi_found = 1'b1;
               w_hi_pick  = c_owner_w'(i);
            end else begin
               w_lo_found = 1'b1;
               w_lo_pick  = c_owner_w'(i);
            end
         end
      end
      w_grant   = w_hi_found ? w_hi_pick : w_lo_pick;
      w_any_req = w_hi_found | w_lo_found;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_last_grant <= c_last_rst;
         r_watchdog   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_nxt;
         r_watchdog   <= w_wd_nxt;
      end
   end

   always_comb begin
      w_state_nxt           = r_state;
      w_owner_nxt           = r_owner;
      w_last_nxt            = r_last_grant;
      w_wd_nxt              = r_watchdog;
      memory_enable         = 1'b0;
      memory_command        = 1'b0;
      read_memory_address   = '0;
      write_memory_address  = '0;
      write_memory_data     = '0;
      write_memory_mask     = '0;
      port_memory_ready     = '0;
      port_memory_valid     = '0;
      port_bus_error        = '0;
      port_read_memory_data = '0;

      case (r_state)
         S_IDLE: begin
            // memory_valid here is spurious and deliberately ignored
            if (w_any_req) begin
               w_owner_nxt = w_grant;
               w_state_nxt = S_ISSUE;
            end
         end

         S_ISSUE: begin
            memory_enable        = port_memory_enable[r_owner];
            memory_command       = port_memory_command[r_owner];
            read_memory_address  = w_raddr[r_owner];
            write_memory_address = w_waddr[r_owner];
            write_memory_data    = w_wdata[r_owner];
            write_memory_mask    = w_wmask[r_owner];
            port_memory_ready    = memory_ready ? w_owner_oh : '0;
            if (!port_memory_enable[r_owner]) begin
               // Owner withdrew before handshake: abandon silently and keep
               // last_grant so the same port is not skipped next round.
               w_state_nxt = S_IDLE;
            end else if (memory_ready) begin
               w_state_nxt = S_WAIT;
               w_wd_nxt    = '0;
            end
         end

         S_WAIT: begin
            // A completion in the expiry cycle takes precedence over the error
            if (memory_valid) begin
               port_memory_valid     = w_owner_oh;
               port_read_memory_data = read_memory_data;
               w_last_nxt            = r_owner;
               w_state_nxt           = S_IDLE;
            end else if (w_expired) begin
               port_bus_error = w_owner_oh;
               w_last_nxt     = r_owner;
               w_state_nxt    = S_IDLE;
            end else if (r_watchdog != c_wd_max) begin
               w_wd_nxt = r_watchdog + 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_core_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_memory_arbiter
//  Purpose  : Directed self-checking bench for core_memory_arbiter
//             (3 ports, TIMEOUT = 4). Expected responses are queued when a
//             request is driven and popped when a valid/error pulse appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_core_memory_arbiter;

   localparam int NP = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic [NP-1:0]       pen, pcmd;
   logic [NP*AW-1:0]    praddr, pwaddr;
   logic [NP*DW-1:0]    pwdata, pwmask;
   logic [NP-1:0]       port_memory_ready, port_memory_valid, port_bus_error;
   logic [DW-1:0]       port_read_memory_data;
   logic                memory_ready, memory_valid;
   logic [DW-1:0]       read_memory_data;
   logic [AW-1:0]       read_memory_address, write_memory_address;
   logic [DW-1:0]       write_memory_data, write_memory_mask;
   logic                memory_command, memory_enable, busy;
   logic [1:0]          debug_owner;

   core_memory_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .port_memory_enable       (pen),
      .port_memory_command      (pcmd),
      .port_read_memory_address (praddr),
      .port_write_memory_address(pwaddr),
      .port_write_memory_data   (pwdata),
      .port_write_memory_mask   (pwmask),
      .port_memory_ready        (port_memory_ready),
      .port_memory_valid        (port_memory_valid),
      .port_read_memory_data    (port_read_memory_data),
      .port_bus_error           (port_bus_error),
      .memory_ready             (memory_ready),
      .memory_valid             (memory_valid),
      .read_memory_data         (read_memory_data),
      .read_memory_address      (read_memory_address),
      .write_memory_address     (write_memory_address),
      .write_memory_data        (write_memory_data),
      .write_memory_mask        (write_memory_mask),
      .memory_command           (memory_command),
      .memory_enable            (memory_enable),
      .busy                     (busy),
      .debug_owner              (debug_owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NP-1:0] vvec;
      logic [NP-1:0] evec;
      logic [DW-1:0] data;
      logic [1:0]    owner;
   } exp_t;

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   int          n_fail  = 0;
   int          vcnt[NP];
   bit          auto_mem = 1'b0;
   logic        hs;
   logic [DW-1:0] hs_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Any valid/error pulse must match the oldest queued expectation.
   task automatic monitor();
      exp_t e;
      if ((port_memory_valid | port_bus_error) != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", {port_memory_valid, port_bus_error}, 64'h0);
         end else begin
            e = sb.pop_front();
            chk("resp_valid", port_memory_valid, e.vvec);
            chk("resp_error", port_bus_error, e.evec);
            chk("resp_owner", debug_owner, e.owner);
            if (e.vvec != '0) chk("resp_data", port_read_memory_data, e.data);
            for (int p = 0; p < NP; p++) if (port_memory_valid[p]) vcnt[p]++;
         end
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      monitor();
      if (auto_mem) begin
         hs      = memory_enable & memory_ready;
         hs_data = read_memory_address ^ 32'hA5A5_A5A5;
      end
   endtask

   // Auto memory model: answers one cycle after each handshake.
   task automatic to_pos();
      @(posedge clk);
      #1;
      if (auto_mem) begin
         memory_valid     = hs;
         read_memory_data = hs ? hs_data : 32'h0;
      end
   endtask

   task automatic check_issue(input int port, input logic cmd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] wmask, input bit rdy);
      logic [NP-1:0] oh;
      oh = NP'(1) << port;
      chk("issue_mem_enable", memory_enable, 1);
      chk("issue_cmd", memory_command, cmd);
      chk("issue_raddr", read_memory_address, cmd ? 32'h0 : addr);
      chk("issue_waddr", write_memory_address, cmd ? addr : 32'h0);
      chk("issue_wdata", write_memory_data, wdata);
      chk("issue_wmask", write_memory_mask, wmask);
      chk("issue_port_ready", port_memory_ready, rdy ? oh : '0);
      chk("issue_owner", debug_owner, port);
      chk("issue_busy", busy, 1);
   endtask

   // lat = 0 means memory never answers (expect bus error after TO cycles)
   task automatic do_txn(input int port, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] wmask,
                         input int stall, input int lat, input logic [31:0] rdata);
      exp_t e;
      int   n_wait;
      logic [NP-1:0] oh;
      oh = NP'(1) << port;
      pen[port]  = 1'b1;
      pcmd[port] = cmd;
      praddr[port*AW +: AW] = cmd ? 32'h0 : addr;
      pwaddr[port*AW +: AW] = cmd ? addr : 32'h0;
      pwdata[port*DW +: DW] = wdata;
      pwmask[port*DW +: DW] = wmask;
      memory_ready = (stall == 0);
      e.vvec  = (lat > 0) ? oh : '0;
      e.evec  = (lat == 0) ? oh : '0;
      e.data  = rdata;
      e.owner = port[1:0];
      sb.push_back(e);
      to_neg();
      chk("arb_idle_busy", busy, 0);
      chk("arb_idle_enable", memory_enable, 0);
      to_pos();
      for (int s = 0; s < stall; s++) begin
         to_neg();
         check_issue(port, cmd, addr, wdata, wmask, 1'b0);
         to_pos();
      end
      memory_ready = 1'b1;
      to_neg();
      check_issue(port, cmd, addr, wdata, wmask, 1'b1);
      to_pos();
      pen[port]    = 1'b0;
      memory_ready = 1'b0;
      n_wait = (lat == 0) ? TO : lat;
      for (int w = 1; w <= n_wait; w++) begin
         if (lat != 0 && w == lat) begin
            memory_valid     = 1'b1;
            read_memory_data = rdata;
         end
         to_neg();
         if (w < n_wait) begin
            chk("wait_no_valid", port_memory_valid, 0);
            chk("wait_no_error", port_bus_error, 0);
            chk("wait_enable_low", memory_enable, 0);
         end else begin
            chk("resp_on_time", sb.size(), 0);
         end
         to_pos();
      end
      memory_valid     = 1'b0;
      read_memory_data = 32'h0;
      to_neg();
      chk("back_to_idle", busy, 0);
      to_pos();
   endtask

   initial begin
      #100000;
      $display("FAIL tb_timeout: simulation exceeded time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      exp_t e;
      for (int p = 0; p < NP; p++) vcnt[p] = 0;
      reset            = 1'b1;
      pen              = 3'b011;
      pcmd             = 3'b000;
      praddr           = {32'hBAD2_0002, 32'hBAD1_0001, 32'hBAD0_0000};
      pwaddr           = {32'hBEE2_0002, 32'hBEE1_0001, 32'hBEE0_0000};
      pwdata           = {32'hD0D2_0002, 32'hD0D1_0001, 32'hD0D0_0000};
      pwmask           = {32'hF0F2_0002, 32'hF0F1_0001, 32'hF0F0_0000};
      memory_ready     = 1'b1;
      memory_valid     = 1'b0;
      read_memory_data = 32'h0;

      // Reset state, with requests pending
      to_neg();
      chk("rst_busy", busy, 0);
      chk("rst_mem_enable", memory_enable, 0);
      chk("rst_mem_cmd", memory_command, 0);
      chk("rst_raddr", read_memory_address, 0);
      chk("rst_waddr", write_memory_address, 0);
      chk("rst_wdata", write_memory_data, 0);
      chk("rst_wmask", write_memory_mask, 0);
      chk("rst_port_ready", port_memory_ready, 0);
      chk("rst_port_valid", port_memory_valid, 0);
      chk("rst_bus_error", port_bus_error, 0);
      chk("rst_rdata", port_read_memory_data, 0);
      chk("rst_owner", debug_owner, 0);
      to_pos();
      reset        = 1'b0;
      pen          = '0;
      memory_ready = 1'b0;
      to_neg();
      to_pos();

      // Round-robin: all ports request continuously, 1-cycle memory
      for (int p = 0; p < NP; p++) praddr[p*AW +: AW] = 32'h1000 + 32'h10 * p;
      for (int k = 0; k < 6; k++) begin
         e.vvec  = NP'(1) << (k % NP);
         e.evec  = '0;
         e.owner = 2'(k % NP);
         e.data  = (32'h1000 + 32'h10 * (k % NP)) ^ 32'hA5A5_A5A5;
         sb.push_back(e);
      end
      pen          = 3'b111;
      memory_ready = 1'b1;
      auto_mem     = 1'b1;
      hs           = 1'b0;
      for (int c = 0; c < 18; c++) begin
         to_neg();
         to_pos();
      end
      pen          = '0;
      memory_ready = 1'b0;
      auto_mem     = 1'b0;
      memory_valid = 1'b0;
      for (int p = 0; p < NP; p++) chk("rr_valid_count", vcnt[p], 2);
      chk("rr_all_served", sb.size(), 0);
      to_neg();
      to_pos();

      // Single read through port 1, valid two cycles after accept
      do_txn(1, 1'b0, 32'h100, 32'h0, 32'h0, 0, 2, 32'hDEAD_BEEF);

      // Write through port 0 with a 3-cycle downstream stall
      do_txn(0, 1'b1, 32'h40, 32'h1234_5678, 32'h0000_FFFF, 3, 1, 32'hCAFE_0003);

      // Timeout: memory never answers; then a normal request
      do_txn(0, 1'b0, 32'h300, 32'h0, 32'h0, 0, 0, 32'h0);
      do_txn(1, 1'b0, 32'h310, 32'h0, 32'h0, 0, 1, 32'h1111_2222);

      // Valid arriving in the expiry cycle wins over the error
      do_txn(2, 1'b0, 32'h400, 32'h0, 32'h0, 0, TO, 32'h5555_AAAA);

      // Spurious memory_valid while idle is not forwarded
      memory_valid     = 1'b1;
      read_memory_data = 32'h7777_7777;
      to_neg();
      chk("spurious_idle_valid", port_memory_valid, 0);
      to_pos();
      memory_valid     = 1'b0;
      read_memory_data = 32'h0;

      // Reset asserted in WAIT; post-reset valid ignored; port 0 granted first
      pen[2]  = 1'b1;
      pcmd[2] = 1'b0;
      praddr[2*AW +: AW] = 32'h200;
      memory_ready = 1'b1;
      to_neg();
      to_pos();
      to_neg();
      chk("mid_issue_owner", debug_owner, 2);
      to_pos();
      pen          = '0;
      memory_ready = 1'b0;
      reset        = 1'b1;
      to_neg();
      chk("midrst_busy", busy, 0);
      chk("midrst_mem_enable", memory_enable, 0);
      chk("midrst_port_valid", port_memory_valid, 0);
      chk("midrst_owner", debug_owner, 0);
      chk("midrst_raddr", read_memory_address, 0);
      to_pos();
      reset            = 1'b0;
      memory_valid     = 1'b1;
      read_memory_data = 32'hFFFF_0000;
      to_neg();
      chk("postrst_valid_ignored", port_memory_valid, 0);
      chk("postrst_busy", busy, 0);
      to_pos();
      memory_valid     = 1'b0;
      read_memory_data = 32'h0;
      pen              = 3'b111;
      memory_ready     = 1'b1;
      e.vvec  = 3'b001;
      e.evec  = 3'b000;
      e.owner = 2'd0;
      e.data  = 32'h600D_F00D;
      sb.push_back(e);
      to_neg();
      to_pos();
      to_neg();
      chk("postrst_first_owner", debug_owner, 0);
      chk("postrst_first_ready", port_memory_ready, 3'b001);
      to_pos();
      pen              = '0;
      memory_ready     = 1'b0;
      memory_valid     = 1'b1;
      read_memory_data = 32'h600D_F00D;
      to_neg();
      chk("postrst_resp_seen", sb.size(), 0);
      to_pos();
      memory_valid     = 1'b0;
      read_memory_data = 32'h0;
      to_neg();
      chk("final_idle", busy, 0);
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
